uart_tx_serial: RTL and testbench

- Serial UART transmitter: the transmit-side counterpart of the team's mkuart_rx receiver.
- Accepts parallel bytes through a BSV-style enable/ready method interface and serialises them onto a single line.
- Frame format: start bit (0), DATA_BITS data bits sent LSB first, optional parity bit, STOP_BITS stop bits (1).
- A one-entry holding register lets the next byte be queued while the current frame shifts out, so frames can go back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_counter.sv | 30 +++
 rtl/uart_tx_serial.sv | 153 +++++++++++++++
 tb/tb_uart_tx_serial.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// default baud divisor that both the transmit and receive sides use.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} TxState;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Modulo-MODULUS counter: runs while en is high, pulses tc on the last count
// and wraps to zero; held at zero while disabled.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned MODULUS = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = cnt_width(MODULUS);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == W'(MODULUS - 1));

  always_comb begin
    cnt_d = '0;
    if (en && !tc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serial.sv
// UART transmitter with enable/ready put interface and a one-entry holding
// register so consecutive frames leave the line with no idle gap.
module uart_tx_serial
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] put_data,
  input  logic                 EN_put,
  output logic                 RDY_put,
  output logic                 tx,
  output logic                 busy
);

  TxState               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_q, hold_d;
  logic [2:0]           bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 tc;
  logic                 accept;
  logic                 load_put;
  logic                 load_hold;

  function automatic logic par_of(input logic [DATA_BITS-1:0] v);
    return (^v) ^ (PARITY == PAR_ODD);
  endfunction

  uart_baud_counter #(.MODULUS(CLKS_PER_BIT)) u_baud (
    .clk (CLK),
    .rst (RST),
    .en  (state_q != IDLE),
    .tc  (tc)
  );

  assign accept  = EN_put && !hold_q;
  assign RDY_put = !hold_q;
  assign busy    = (state_q != IDLE) || hold_q;
  assign tx      = tx_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_data_d = hold_data_q;
    bit_d       = bit_q;
    par_d       = par_q;
    load_put    = 1'b0;
    load_hold   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load_put = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tc) begin
          shift_d = shift_q >> 1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (tc) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (tc) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            // A held byte wins; otherwise a put on this very edge chains straight in.
            if (hold_q) begin
              load_hold = 1'b1;
              state_d   = START;
            end else if (accept) begin
              load_put = 1'b1;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_put) begin
      shift_d = put_data;
      par_d   = par_of(put_data);
    end
    if (load_hold) begin
      shift_d = hold_data_q;
      par_d   = par_of(hold_data_q);
      hold_d  = 1'b0;
    end
    if (accept && !load_put) begin
      hold_d      = 1'b1;
      hold_data_d = put_data;
    end

    // tx is registered from the next state so it lines up with state_q.
    case (state_d)
      START:            tx_d = 1'b0;
      DATA:             tx_d = shift_d[0];
      uart_pkg::PARITY: tx_d = par_d;
      default:          tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= 1'b0;
      hold_data_q <= '0;
      bit_q       <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_data_q <= hold_data_d;
      bit_q       <= bit_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial: four parameterisations sharing one clock
// and reset, frames checked bit-cycle by bit-cycle against hand-built vectors.
module tb_uart_tx_serial;

  logic       CLK;
  logic       RST;
  logic [7:0] data_w [4];
  logic       en_w   [4];
  logic       rdy_w  [4];
  logic       tx_w   [4];
  logic       busy_w [4];

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_serial #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .put_data(data_w[0]), .EN_put(en_w[0]),
    .RDY_put(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx_serial #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .CLK(CLK), .RST(RST), .put_data(data_w[1]), .EN_put(en_w[1]),
    .RDY_put(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx_serial #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .CLK(CLK), .RST(RST), .put_data(data_w[2]), .EN_put(en_w[2]),
    .RDY_put(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  uart_tx_serial #(.CLKS_PER_BIT(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .CLK(CLK), .RST(RST), .put_data(data_w[3]), .EN_put(en_w[3]),
    .RDY_put(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int d, input string tag);
    check({tag, "_tx"},   32'(tx_w[d]),   32'd1);
    check({tag, "_busy"}, 32'(busy_w[d]), 32'd0);
    check({tag, "_rdy"},  32'(rdy_w[d]),  32'd1);
  endtask

  // bits[0] is the start bit; cycles [first,last) of the frame are checked.
  task automatic expect_frame(input int d, input string tag, input logic [15:0] bits,
                              input int cpb, input int first, input int last,
                              input logic exp_rdy);
    for (int c = first; c < last; c++) begin
      check($sformatf("%s_tx%0d", tag, c),   32'(tx_w[d]),   32'(bits[c / cpb]));
      check($sformatf("%s_busy%0d", tag, c), 32'(busy_w[d]), 32'd1);
      check($sformatf("%s_rdy%0d", tag, c),  32'(rdy_w[d]),  32'(exp_rdy));
      step();
      en_w[d] = 1'b0;
    end
  endtask

  task automatic put(input int d, input logic [7:0] v);
    data_w[d] = v;
    en_w[d]   = 1'b1;
    step();
    en_w[d]   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      data_w[i] = '0;
      en_w[i]   = 1'b0;
    end
    RST = 1'b1;
    step();
    step();
    idle_check(0, "rst_held");
    RST = 1'b0;
    step();
    idle_check(0, "rst_rel");
    idle_check(3, "rst_rel3");

    // 1: single frame 0xA5, 40 cycles
    put(0, 8'hA5);
    expect_frame(0, "t1", {6'b0, 1'b1, 8'hA5, 1'b0}, 4, 0, 40, 1'b1);
    idle_check(0, "t1_end");

    // 2: 0x3C then 0xC3 queued during the first START cycle, back to back
    put(0, 8'h3C);
    check("t2_rdy_before", 32'(rdy_w[0]), 32'd1);
    put(0, 8'hC3);
    expect_frame(0, "t2a", {6'b0, 1'b1, 8'h3C, 1'b0}, 4, 1, 40, 1'b0);
    expect_frame(0, "t2b", {6'b0, 1'b1, 8'hC3, 1'b0}, 4, 0, 40, 1'b1);
    idle_check(0, "t2_end");

    // 3: even and odd parity on 0x07
    put(1, 8'h07);
    expect_frame(1, "t3e", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 4, 0, 44, 1'b1);
    idle_check(1, "t3e_end");
    put(2, 8'h07);
    expect_frame(2, "t3o", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 4, 0, 44, 1'b1);
    idle_check(2, "t3o_end");

    // 4: put of 0x55 while the holding register is full is dropped
    put(0, 8'h11);
    put(0, 8'h22);
    data_w[0] = 8'h55;
    en_w[0]   = 1'b1;
    expect_frame(0, "t4a", {6'b0, 1'b1, 8'h11, 1'b0}, 4, 1, 40, 1'b0);
    expect_frame(0, "t4b", {6'b0, 1'b1, 8'h22, 1'b0}, 4, 0, 40, 1'b1);
    idle_check(0, "t4_end");

    // 5: asynchronous reset mid-DATA with a byte held
    put(0, 8'hFF);
    put(0, 8'h0F);
    check("t5_rdy_held", 32'(rdy_w[0]), 32'd0);
    repeat (5) step();
    check("t5_busy_mid", 32'(busy_w[0]), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    idle_check(0, "t5_async");
    step();
    RST = 1'b0;
    step();
    idle_check(0, "t5_post");
    put(0, 8'h81);
    expect_frame(0, "t5", {6'b0, 1'b1, 8'h81, 1'b0}, 4, 0, 40, 1'b1);
    idle_check(0, "t5_end");

    // 6: two stop bits at two clocks per bit
    put(3, 8'h00);
    expect_frame(3, "t6", {5'b0, 2'b11, 8'h00, 1'b0}, 2, 0, 22, 1'b1);
    idle_check(3, "t6_end");

    // 7: put lands on the final STOP edge with the holding register empty
    put(0, 8'h5A);
    expect_frame(0, "t7a", {6'b0, 1'b1, 8'h5A, 1'b0}, 4, 0, 39, 1'b1);
    check("t7_last_stop", 32'(tx_w[0]), 32'd1);
    put(0, 8'h96);
    expect_frame(0, "t7b", {6'b0, 1'b1, 8'h96, 1'b0}, 4, 0, 40, 1'b1);
    idle_check(0, "t7_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
